// File: rtl/perceptron_ctrl.sv
// -----------------------------------------------------------------------------
// perceptron_ctrl
//
// Sequencing controller for the 10-input floating-point perceptron datapath.
// It streams a weight set from a weight memory into the datapath's serial
// weight register, gates upstream input vectors into the datapath with a
// valid/ready handshake, and counts vectors in flight. A weight reload waits
// until every issued vector has returned, so no vector is ever computed
// against a mixed weight set.
//
// Parameters
//   AW            weight memory address width
//   N_W           weights per set (datapath input count)
//   MAX_INFLIGHT  maximum vectors issued but not yet returned
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   cfg_req        level request to load a weight set (held until cfg_ack)
//   cfg_base       base address of the weight set (stable while cfg_req)
//   cfg_ack        one-cycle pulse: weight set fully loaded
//   wmem_rd        weight memory read strobe
//   wmem_addr      weight memory read address
//   wmem_rdata     read data, valid one cycle after wmem_rd
//   w              weight word to the datapath serial weight register
//   load_weight    shift enable for w
//   vec_valid      upstream input vector present
//   vec_ready      controller accepts a vector (combinational)
//   valid_in       vector issued to the datapath (combinational)
//   dp_valid_out   datapath result valid
//   inflight       vectors in flight
//   weights_ok     a complete weight set is loaded
//   err_underflow  sticky: result seen with nothing in flight
// -----------------------------------------------------------------------------
module perceptron_ctrl #(
  parameter int AW           = 8,
  parameter int N_W          = 10,
  parameter int MAX_INFLIGHT = 16,
  localparam int IW          = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  // configuration handshake
  input  logic          cfg_req,
  input  logic [AW-1:0] cfg_base,
  output logic          cfg_ack,
  // weight memory
  output logic          wmem_rd,
  output logic [AW-1:0] wmem_addr,
  input  logic [31:0]   wmem_rdata,
  // datapath weight shift port
  output logic [31:0]   w,
  output logic          load_weight,
  // vector handshake
  input  logic          vec_valid,
  output logic          vec_ready,
  output logic          valid_in,
  input  logic          dp_valid_out,
  // status
  output logic [IW-1:0] inflight,
  output logic          weights_ok,
  output logic          err_underflow
);

  // Read counter runs 0..N_W; the value N_W marks the final shift cycle.
  localparam int KW = $clog2(N_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          wmem_rd_q, wmem_rd_d;
  logic [AW-1:0] wmem_addr_q, wmem_addr_d;
  logic          load_weight_q, load_weight_d;
  logic          cfg_ack_q, cfg_ack_d;
  logic          weights_ok_q, weights_ok_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic          err_underflow_q, err_underflow_d;

  logic          enter_load;
  logic          read_more;

  // ---------------------------------------------------------------------------
  // State register and all other flops
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      k_q             <= '0;
      wmem_rd_q       <= 1'b0;
      wmem_addr_q     <= '0;
      load_weight_q   <= 1'b0;
      cfg_ack_q       <= 1'b0;
      weights_ok_q    <= 1'b0;
      inflight_q      <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      wmem_rd_q       <= wmem_rd_d;
      wmem_addr_q     <= wmem_addr_d;
      load_weight_q   <= load_weight_d;
      cfg_ack_q       <= cfg_ack_d;
      weights_ok_q    <= weights_ok_d;
      inflight_q      <= inflight_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    enter_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_req) begin
          state_d    = S_LOAD;
          enter_load = 1'b1;
        end
      end
      S_LOAD: begin
        // Stay through the last shift cycle (the one carrying cfg_ack).
        if (k_q == KW'(N_W)) state_d = S_RUN;
      end
      S_RUN: begin
        if (cfg_req) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Only once nothing is in flight may the weights change.
        if (inflight_q == '0) begin
          state_d    = S_LOAD;
          enter_load = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load sequencer, in-flight counter and status (next values of registers)
  // ---------------------------------------------------------------------------
  always_comb begin
    // A read is issued on LOAD entry and for k = 0..N_W-2 while in LOAD, so
    // reads land on T..T+N_W-1 with addresses base..base+N_W-1.
    read_more = (state_q == S_LOAD) && (k_q < KW'(N_W - 1));

    k_d = k_q;
    if (enter_load) begin
      k_d = '0;
    end else if ((state_q == S_LOAD) && (k_q != KW'(N_W))) begin
      k_d = k_q + 1'b1;
    end

    wmem_rd_d   = enter_load | read_more;

    wmem_addr_d = wmem_addr_q;
    if (enter_load) begin
      wmem_addr_d = cfg_base;
    end else if (read_more) begin
      wmem_addr_d = wmem_addr_q + 1'b1;   // wraps modulo 2^AW
    end

    // Data returns one cycle after each read; shift it in that same cycle.
    load_weight_d = (state_q == S_LOAD) && wmem_rd_q;
    cfg_ack_d     = (state_q == S_LOAD) && (k_q == KW'(N_W - 1));

    // A set is complete from the first RUN cycle; it stays valid while
    // draining and is invalidated when the next load begins.
    weights_ok_d  = (state_d == S_RUN) || (state_d == S_DRAIN);

    inflight_d      = inflight_q;
    err_underflow_d = err_underflow_q;
    if (dp_valid_out && (inflight_q == '0)) begin
      err_underflow_d = 1'b1;
    end
    if (valid_in && !dp_valid_out) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!valid_in && dp_valid_out && (inflight_q != '0)) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Ready drops in the same cycle cfg_req rises so nothing new is issued
    // once a reload is pending.
    vec_ready = (state_q == S_RUN) && (inflight_q < IW'(MAX_INFLIGHT)) && !cfg_req;
    valid_in  = vec_valid && vec_ready;
    // The memory's read data is already a register output aligned with
    // load_weight; another flop here would put w one cycle behind its strobe.
    w         = load_weight_q ? wmem_rdata : 32'd0;
  end

  assign cfg_ack       = cfg_ack_q;
  assign wmem_rd       = wmem_rd_q;
  assign wmem_addr     = wmem_addr_q;
  assign load_weight   = load_weight_q;
  assign inflight      = inflight_q;
  assign weights_ok    = weights_ok_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_perceptron_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_perceptron_ctrl
//
// Directed bench for perceptron_ctrl: reset state, a plain weight load, a
// wrapping load started from DRAIN, back-pressure at the in-flight limit,
// reset in the middle of a load, and the sticky underflow flag. A small
// registered memory model answers the weight reads.
// -----------------------------------------------------------------------------
module tb_perceptron_ctrl;

  localparam int AW  = 8;
  localparam int N_W = 10;
  localparam int MAX = 16;
  localparam int IW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_req;
  logic [AW-1:0] cfg_base;
  logic          cfg_ack;
  logic          wmem_rd;
  logic [AW-1:0] wmem_addr;
  logic [31:0]   wmem_rdata;
  logic [31:0]   w;
  logic          load_weight;
  logic          vec_valid;
  logic          vec_ready;
  logic          valid_in;
  logic          dp_valid_out;
  logic [IW-1:0] inflight;
  logic          weights_ok;
  logic          err_underflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [256];

  perceptron_ctrl #(.AW(AW), .N_W(N_W), .MAX_INFLIGHT(MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_req      (cfg_req),
    .cfg_base     (cfg_base),
    .cfg_ack      (cfg_ack),
    .wmem_rd      (wmem_rd),
    .wmem_addr    (wmem_addr),
    .wmem_rdata   (wmem_rdata),
    .w            (w),
    .load_weight  (load_weight),
    .vec_valid    (vec_valid),
    .vec_ready    (vec_ready),
    .valid_in     (valid_in),
    .dp_valid_out (dp_valid_out),
    .inflight     (inflight),
    .weights_ok   (weights_ok),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Synchronous-read weight memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (wmem_rd) wmem_rdata <= mem[wmem_addr];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Moves to 1ns after the next rising edge; inputs are driven here and
  // outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects cfg_req already high with cfg_base set. Waits (bounded) for the
  // first read, then checks the full read/shift/ack sequence and the first
  // RUN cycle. Drops cfg_req on cfg_ack. 'waited' = cycles to first read.
  task automatic load_seq(input logic [AW-1:0] base, output int waited);
    logic [AW-1:0] a;
    waited = 0;
    do begin
      step(); #1;
      waited++;
    end while (wmem_rd !== 1'b1 && waited < 200);
    check("load_start", 32'(wmem_rd), 32'd1);
    if (wmem_rd !== 1'b1) return;
    check("addr_k0", 32'(wmem_addr), 32'(base));
    check("lw_T", 32'(load_weight), 32'd0);
    check("wok_T", 32'(weights_ok), 32'd0);
    for (int i = 1; i <= N_W; i++) begin
      step(); #1;
      a = base + AW'(i - 1);
      check("lw", 32'(load_weight), 32'd1);
      check("w", w, mem[a]);
      check("rd", 32'(wmem_rd), 32'(i < N_W));
      if (i < N_W) check("addr", 32'(wmem_addr), 32'(AW'(base + AW'(i))));
      check("ack", 32'(cfg_ack), 32'(i == N_W));
      check("wok_load", 32'(weights_ok), 32'd0);
    end
    cfg_req = 1'b0;
    step(); #1;
    check("wok_run", 32'(weights_ok), 32'd1);
    check("ack_after", 32'(cfg_ack), 32'd0);
    check("lw_after", 32'(load_weight), 32'd0);
    check("ready_run", 32'(vec_ready), 32'd1);
  endtask

  int waited;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    for (int i = 0; i < N_W; i++) mem[8'h10 + i] = 32'(i + 1);

    rst = 1'b1; cfg_req = 1'b0; cfg_base = '0; vec_valid = 1'b0; dp_valid_out = 1'b0;

    // ---- reset state ----
    repeat (2) step();
    vec_valid = 1'b1;
    #1;
    check("rst_ack", 32'(cfg_ack), 32'd0);
    check("rst_rd", 32'(wmem_rd), 32'd0);
    check("rst_addr", 32'(wmem_addr), 32'd0);
    check("rst_w", w, 32'd0);
    check("rst_lw", 32'(load_weight), 32'd0);
    check("rst_ready", 32'(vec_ready), 32'd0);
    check("rst_valid_in", 32'(valid_in), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_wok", 32'(weights_ok), 32'd0);
    check("rst_err", 32'(err_underflow), 32'd0);

    step(); rst = 1'b0; #1;
    check("idle_ready", 32'(vec_ready), 32'd0);

    // ---- plain load from IDLE: base 0x10, w = 1..10 ----
    vec_valid = 1'b0; cfg_req = 1'b1; cfg_base = 8'h10;
    load_seq(8'h10, waited);
    check("idle_load_latency", 32'(waited), 32'd1);

    // ---- back-pressure: 16 issues then stall ----
    for (int i = 0; i < MAX; i++) begin
      step(); vec_valid = 1'b1; #1;
      check("bp_inflight", 32'(inflight), 32'(i));
      check("bp_issue", 32'(valid_in), 32'd1);
    end
    step(); #1;
    check("full_inflight", 32'(inflight), 32'd16);
    check("full_ready", 32'(vec_ready), 32'd0);
    check("full_valid_in", 32'(valid_in), 32'd0);
    dp_valid_out = 1'b1; #1;
    check("full_ret_no_issue", 32'(valid_in), 32'd0);
    step(); dp_valid_out = 1'b0; #1;
    check("one_ret_inflight", 32'(inflight), 32'd15);
    check("one_more_issue", 32'(valid_in), 32'd1);
    step(); #1;
    check("refull_inflight", 32'(inflight), 32'd16);
    dp_valid_out = 1'b1;
    step(); #1;
    check("pre_sim_inflight", 32'(inflight), 32'd15);
    check("sim_issue", 32'(valid_in), 32'd1);
    // issue and return together in this cycle
    step(); vec_valid = 1'b0; #1;
    check("sim_unchanged", 32'(inflight), 32'd15);
    repeat (9) step();
    step(); dp_valid_out = 1'b0;

    // ---- reload under load: inflight 5, base 0xFA (wraps) ----
    cfg_req = 1'b1; cfg_base = 8'hFA; vec_valid = 1'b1; #1;
    check("drain_start_inflight", 32'(inflight), 32'd5);
    check("drain_ready_same_cycle", 32'(vec_ready), 32'd0);
    check("drain_no_issue", 32'(valid_in), 32'd0);
    for (int r = 0; r < 5; r++) begin
      step(); dp_valid_out = 1'b1; #1;
      check("drain_inflight", 32'(inflight), 32'(5 - r));
      check("drain_no_lw", 32'(load_weight), 32'd0);
      check("drain_no_rd", 32'(wmem_rd), 32'd0);
      check("drain_no_issue2", 32'(valid_in), 32'd0);
    end
    step(); dp_valid_out = 1'b0; vec_valid = 1'b0; #1;
    check("drained", 32'(inflight), 32'd0);
    check("drained_no_rd", 32'(wmem_rd), 32'd0);
    load_seq(8'hFA, waited);
    check("drain_load_latency", 32'(waited), 32'd1);

    // ---- reset at read k=4 of a load ----
    step(); cfg_req = 1'b1; cfg_base = 8'h40;
    waited = 0;
    do begin step(); #1; waited++; end while (wmem_rd !== 1'b1 && waited < 200);
    check("mid_load_start", 32'(wmem_rd), 32'd1);
    repeat (4) step();
    #1;
    check("mid_addr_k4", 32'(wmem_addr), 32'h44);
    rst = 1'b1; cfg_req = 1'b0;
    step(); rst = 1'b0; #1;
    check("mid_rst_lw", 32'(load_weight), 32'd0);
    check("mid_rst_wok", 32'(weights_ok), 32'd0);
    check("mid_rst_rd", 32'(wmem_rd), 32'd0);
    check("mid_rst_ack", 32'(cfg_ack), 32'd0);
    check("mid_rst_w", w, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      check("mid_rst_idle_lw", 32'(load_weight), 32'd0);
    end
    cfg_req = 1'b1; cfg_base = 8'h10;
    load_seq(8'h10, waited);
    check("reload_latency", 32'(waited), 32'd1);

    // ---- underflow ----
    step(); dp_valid_out = 1'b1; #1;
    check("uf_before", 32'(err_underflow), 32'd0);
    step(); dp_valid_out = 1'b0; #1;
    check("uf_set", 32'(err_underflow), 32'd1);
    check("uf_inflight", 32'(inflight), 32'd0);
    step(); vec_valid = 1'b1;
    step(); step();
    step(); vec_valid = 1'b0; dp_valid_out = 1'b1; #1;
    check("uf_traffic_inflight", 32'(inflight), 32'd3);
    step(); step();
    step(); dp_valid_out = 1'b0; #1;
    check("uf_sticky", 32'(err_underflow), 32'd1);
    check("uf_back_to_zero", 32'(inflight), 32'd0);
    rst = 1'b1;
    step(); rst = 1'b0; #1;
    check("uf_cleared", 32'(err_underflow), 32'd0);
    check("uf_rst_wok", 32'(weights_ok), 32'd0);
    check("uf_rst_ready", 32'(vec_ready), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/perceptron_ctrl.md
# perceptron_ctrl

Sequencing controller for the 10-input floating-point perceptron datapath. It streams a 10-word weight set from a weight memory into the datapath's serial weight register. It gates upstream input vectors into the datapath with a valid/ready handshake and tracks in-flight vectors. It forbids any weight reload until the multiply/add pipeline has drained, so no vector is ever computed against a mixed weight set.

## Interface
- AW, 8, weight memory address width
- N_W, 10, weights per set (equal to datapath input count)
- MAX_INFLIGHT, 16, maximum vectors issued but not yet returned
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_req  in  1  level request to load a weight set; held, with cfg_base stable, until cfg_ack
- cfg_base  in  AW  base address of the weight set
- cfg_ack  out  1  one-cycle pulse: weight set fully loaded
- wmem_rd  out  1  weight memory read strobe
- wmem_addr  out  AW  weight memory read address
- wmem_rdata  in  32  read data, valid exactly 1 cycle after wmem_rd
- w  out  32  weight word to the datapath serial weight register
- load_weight  out  1  shift enable for w
- vec_valid  in  1  upstream input vector present (data routed directly to datapath in0..in9)
- vec_ready  out  1  controller accepts vector
- valid_in  out  1  vector issued to datapath (= vec_valid & vec_ready)
- dp_valid_out  in  1  datapath result valid
- inflight  out  clog2(MAX_INFLIGHT+1)  vectors in flight
- weights_ok  out  1  a complete weight set is loaded
- err_underflow  out  1  sticky: dp_valid_out seen with inflight==0

## Operation
- States: IDLE, LOAD, DRAIN, RUN.
- IDLE (after reset): weights_ok=0, vec_ready=0. If cfg_req=1, latch cfg_base and go to LOAD.
- LOAD: read counter k runs 0..N_W-1, one word per cycle.
  - wmem_rd=1 and wmem_addr=base+k for k=0..N_W-1, with address wrapping modulo 2^AW.
  - One cycle after each read: load_weight=1 and w=wmem_rdata. Words are presented in address order.
  - cfg_ack pulses in the cycle of the final load_weight. Next state is RUN. weights_ok goes to 1 from that next cycle.
  - weights_ok is held 0 throughout LOAD.
- RUN:
  - vec_ready = (inflight < MAX_INFLIGHT) & !cfg_req.
  - If cfg_req=1, go to DRAIN (vec_ready drops in the same cycle, combinationally).
- DRAIN: vec_ready=0. When inflight==0, latch cfg_base and go to LOAD. No issue is possible in DRAIN.
- cfg_req still high in the cycle after cfg_ack counts as a new request. Requesters must drop it on cfg_ack.
- Inflight counter:
  - +1 on valid_in.
  - −1 on dp_valid_out.
  - Unchanged when both occur in the same cycle.
  - Issue at MAX_INFLIGHT is impossible because ready is gated.
- Underflow: dp_valid_out with inflight==0 leaves the counter at 0 and sets err_underflow. err_underflow clears only on rst.
- Reset mid-LOAD or mid-DRAIN: go to IDLE immediately. Clear all counters and weights_ok. No further load_weight. The partial set is treated as invalid.

## Timing
- Reset values: cfg_ack=0, wmem_rd=0, wmem_addr=0, w=0, load_weight=0, vec_ready=0, valid_in=0, inflight=0, weights_ok=0, err_underflow=0.
- All outputs are registered except vec_ready and valid_in, which are combinational from state, inflight, cfg_req and vec_valid.
- Load latency, with T = first LOAD cycle:
  - Reads occur T..T+N_W−1.
  - load_weight is high for T+1..T+N_W (exactly N_W consecutive cycles).
  - cfg_ack is high at T+N_W.
  - First vec_ready is possible at T+N_W+1.
- IDLE→LOAD: cfg_req sampled high at cycle C gives T=C+1.
- DRAIN→LOAD: T = the cycle after inflight is first observed as 0.
- Throughput in RUN: one vector per cycle while inflight < MAX_INFLIGHT.

## Test plan
- Reset, then cfg_req with base=0x10 and memory[0x10+i]=i+1 → reads 0x10..0x19; load_weight high for 10 cycles with w=1..10; cfg_ack at T+10; weights_ok=1 and vec_ready=1 at T+11.
- Wrap: base=0xFA → addresses 0xFA..0xFF, then 0x00..0x03.
- Back-pressure: vec_valid held high with datapath returning nothing → 16 issues, then vec_ready=0 with inflight=16. One dp_valid_out → inflight=15 and one more issue. Simultaneous issue and return → inflight unchanged.
- Reload under load: inflight=5 and cfg_req asserted → vec_ready=0 the same cycle; no load_weight until 5 returns bring inflight to 0; LOAD starts the next cycle.
- Reset at read k=4 of LOAD → IDLE next cycle; load_weight=0 and weights_ok=0; a new cfg_req performs a full 10-word load.
- dp_valid_out with inflight=0 → err_underflow=1 and stays 1 through further traffic; inflight stays 0; err_underflow clears on rst.
